// File: rtl/cache_line_fill_ctrl_if.sv
// Line-fill controller bus: miss request, memory read port, array write port.
// master = controller, slave = cache/memory side.
interface cache_line_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
);
  localparam int OFF = $clog2(WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_data_valid;
  logic              fsm_busy;
  logic              write_data_array;
  logic [OFF-1:0]    write_word_idx;
  logic [DATA_W-1:0] write_data;
  logic              write_tag_array;
  logic              fwd_valid;
  logic [DATA_W-1:0] fwd_data;
  logic              fill_done;

  modport master (
    input  miss_detected, miss_address,
    input  mem_req_ready, mem_data, mem_data_valid,
    output mem_req_valid, mem_address, fsm_busy,
    output write_data_array, write_word_idx, write_data,
    output write_tag_array, fwd_valid, fwd_data, fill_done
  );

  modport slave (
    output miss_detected, miss_address,
    output mem_req_ready, mem_data, mem_data_valid,
    input  mem_req_valid, mem_address, fsm_busy,
    input  write_data_array, write_word_idx, write_data,
    input  write_tag_array, fwd_valid, fwd_data, fill_done
  );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Pipelined cache line-fill controller, up to MAX_OUT reads in flight,
// optional critical-word-first order with early forwarding of the missed word.
module cache_line_fill_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 8,
  parameter int MAX_OUT = 4,
  parameter int CWF     = 1
) (
  input logic clk,
  input logic rst_n,
  cache_line_fill_ctrl_if.master bus
);
  localparam int BSH = $clog2(DATA_W / 8);
  localparam int OFF = $clog2(WORDS);
  localparam int OW  = $clog2(MAX_OUT) + 1;
  localparam logic [ADDR_W-1:0] LMASK =
    ~((ADDR_W'(1) << (OFF + BSH)) - ADDR_W'(1));

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [OFF-1:0]    r_crit;
  logic [OFF:0]      r_issue;
  logic [OFF-1:0]    r_rsp;
  logic [OW-1:0]     r_out;

  logic           w_fill;
  logic           w_req_v;
  logic           w_iss;
  logic           w_rsp;
  logic           w_last;
  logic [OFF-1:0] w_req_idx;
  logic [OFF-1:0] w_rsp_idx;

  assign w_fill = (r_state == S_FILL);

  always_comb begin
    w_req_idx = r_issue[OFF-1:0];
    w_rsp_idx = r_rsp;
    if (CWF != 0) begin
      w_req_idx = r_crit + r_issue[OFF-1:0];
      w_rsp_idx = r_crit + r_rsp;
    end
  end

  // r_issue[OFF] set means all WORDS requests have gone out
  assign w_req_v = w_fill & ~r_issue[OFF] &
                   (r_out < OW'(MAX_OUT));
  assign w_iss   = w_req_v & bus.mem_req_ready;
  assign w_rsp   = w_fill & bus.mem_data_valid;
  assign w_last  = w_rsp & (&r_rsp);

  assign bus.mem_req_valid = w_req_v;
  assign bus.mem_address   = w_fill ?
    (r_base | (ADDR_W'(w_req_idx) << BSH)) : '0;

  assign bus.write_data_array = w_rsp;
  assign bus.write_word_idx   = w_rsp ? w_rsp_idx : '0;
  assign bus.write_data       = bus.mem_data;
  assign bus.write_tag_array  = w_last;
  assign bus.fill_done        = w_last;
  assign bus.fwd_valid        = w_rsp & (w_rsp_idx == r_crit);
  assign bus.fwd_data         = bus.mem_data;

  // stall must already cover the cycle the miss is raised
  assign bus.fsm_busy = w_fill | (rst_n & bus.miss_detected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_crit  <= '0;
      r_issue <= '0;
      r_rsp   <= '0;
      r_out   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.miss_detected) begin
            r_base  <= bus.miss_address & LMASK;
            r_crit  <= bus.miss_address[OFF+BSH-1:BSH];
            r_issue <= '0;
            r_rsp   <= '0;
            r_out   <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_iss) r_issue <= r_issue + (OFF+1)'(1);
          if (w_rsp) r_rsp <= r_rsp + OFF'(1);
          r_out <= r_out + OW'(w_iss) - OW'(w_rsp);
          if (w_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Randomized bench for cache_line_fill_ctrl: two configurations
// (CWF=1/MAX_OUT=4 and CWF=0/MAX_OUT=2) against a line-level reference model.
module tb_cache_line_fill_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        miss;
  logic [15:0] maddr;
  logic        rdy;
  logic        spur;
  logic        tmo;
  int          lat;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [15:0] mem [0:32767];

  cache_line_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16), .WORDS(W)) bus0 ();
  cache_line_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16), .WORDS(W)) bus1 ();

  assign bus0.miss_detected = miss;
  assign bus0.miss_address  = maddr;
  assign bus0.mem_req_ready = rdy;
  assign bus1.miss_detected = miss;
  assign bus1.miss_address  = maddr;
  assign bus1.mem_req_ready = rdy;

  cache_line_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(W),
    .MAX_OUT(4), .CWF(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cache_line_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(W),
    .MAX_OUT(2), .CWF(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic rv; logic [15:0] ra; logic busy;
    logic wda; logic [2:0] wi; logic [15:0] wd;
    logic wt; logic fv; logic [15:0] fd; logic dn;
    logic dv; logic [15:0] dd; logic rdy; logic miss;
    logic [15:0] ma;
  } obs_t;

  // reference model state, one slot per configuration
  bit          m_busy [2];
  int          m_iss  [2];
  int          m_rsp  [2];
  int          m_crit [2];
  logic [15:0] m_base [2];
  int          m_mcyc [2];
  bit          m_full [2];
  bit          m_stl  [2];
  logic [15:0] m_sa   [2];
  int          q_due  [2][$];
  logic [15:0] q_addr [2][$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int mo(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int widx(input int i, input int k);
    return (i == 0) ? (m_crit[i] + k) % W : k;
  endfunction

  task automatic step(input int i, input obs_t o);
    int idx;
    bit erv;
    bit last;
    logic [15:0] ea;
    if (!rst_n) begin
      chk("rst_req_v", 32'(o.rv), 0);
      chk("rst_addr", 32'(o.ra), 0);
      chk("rst_wr_en", 32'(o.wda), 0);
      chk("rst_wr_idx", 32'(o.wi), 0);
      chk("rst_tag", 32'(o.wt), 0);
      chk("rst_fwd_v", 32'(o.fv), 0);
      chk("rst_done", 32'(o.dn), 0);
      chk("rst_busy", 32'(o.busy), 0);
      m_busy[i] = 0;
      m_stl[i]  = 0;
      q_due[i].delete();
      q_addr[i].delete();
      return;
    end
    chk("busy", 32'(o.busy), 32'(m_busy[i] | o.miss));
    erv = m_busy[i] && (m_iss[i] < W) &&
          ((m_iss[i] - m_rsp[i]) < mo(i));
    chk("req_v", 32'(o.rv), 32'(erv));
    if (o.rv) begin
      ea = m_base[i] | 16'(widx(i, m_iss[i]) * 2);
      chk("req_addr", 32'(o.ra), 32'(ea));
      if (m_stl[i]) chk("hold_addr", 32'(o.ra), 32'(m_sa[i]));
    end
    m_stl[i] = o.rv & ~o.rdy;
    m_sa[i]  = o.ra;
    last = 0;
    if (m_busy[i] && o.dv) begin
      idx = widx(i, m_rsp[i]);
      ea  = m_base[i] | 16'(idx * 2);
      last = (m_rsp[i] == W - 1);
      chk("wr_en", 32'(o.wda), 1);
      chk("wr_idx", 32'(o.wi), 32'(idx));
      chk("wr_data", 32'(o.wd), 32'(mem[ea[15:1]]));
      chk("fwd_v", 32'(o.fv), 32'(idx == m_crit[i]));
      if (idx == m_crit[i])
        chk("fwd_data", 32'(o.fd), 32'(mem[ea[15:1]]));
      chk("tag", 32'(o.wt), 32'(last));
      chk("done", 32'(o.dn), 32'(last));
    end else begin
      chk("wr_en", 32'(o.wda), 0);
      chk("fwd_v", 32'(o.fv), 0);
      chk("tag", 32'(o.wt), 0);
      chk("done", 32'(o.dn), 0);
    end
    if (m_busy[i] && o.rv && o.rdy) begin
      q_due[i].push_back(cyc + lat);
      q_addr[i].push_back(o.ra);
      m_iss[i]++;
    end
    if (m_busy[i] && !o.rdy) m_full[i] = 0;
    if (m_busy[i] && o.dv) begin
      m_rsp[i]++;
      if (last) begin
        m_busy[i] = 0;
        if (m_full[i] && mo(i) >= lat + 1)
          chk("fill_cycles", 32'(cyc - m_mcyc[i]), 32'(1 + lat + W - 1));
      end
    end else if (!m_busy[i] && o.miss) begin
      m_busy[i] = 1;
      m_base[i] = o.ma & 16'hFFF0;
      m_crit[i] = int'(o.ma[3:1]);
      m_iss[i]  = 0;
      m_rsp[i]  = 0;
      m_mcyc[i] = cyc;
      m_full[i] = 1;
    end
  endtask

  // memory responder + monitor, single process for both configurations
  initial begin
    obs_t o [2];
    logic dv [2];
    logic [15:0] dd [2];
    logic [15:0] qa;
    bus0.mem_data_valid = 1'b0;
    bus0.mem_data = '0;
    bus1.mem_data_valid = 1'b0;
    bus1.mem_data = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        dv[i] = 1'b0;
        dd[i] = 16'($urandom);
        if (q_due[i].size() > 0 && q_due[i][0] <= cyc) begin
          qa = q_addr[i].pop_front();
          void'(q_due[i].pop_front());
          dv[i] = 1'b1;
          dd[i] = mem[qa[15:1]];
        end else if (!m_busy[i] && spur) begin
          dv[i] = 1'($urandom);
        end
      end
      bus0.mem_data_valid = dv[0];
      bus0.mem_data = dd[0];
      bus1.mem_data_valid = dv[1];
      bus1.mem_data = dd[1];
      @(negedge clk);
      o[0].rv = bus0.mem_req_valid; o[0].ra = bus0.mem_address;
      o[0].busy = bus0.fsm_busy; o[0].wda = bus0.write_data_array;
      o[0].wi = bus0.write_word_idx; o[0].wd = bus0.write_data;
      o[0].wt = bus0.write_tag_array; o[0].fv = bus0.fwd_valid;
      o[0].fd = bus0.fwd_data; o[0].dn = bus0.fill_done;
      o[0].dv = bus0.mem_data_valid; o[0].dd = bus0.mem_data;
      o[0].rdy = rdy; o[0].miss = miss; o[0].ma = maddr;
      o[1].rv = bus1.mem_req_valid; o[1].ra = bus1.mem_address;
      o[1].busy = bus1.fsm_busy; o[1].wda = bus1.write_data_array;
      o[1].wi = bus1.write_word_idx; o[1].wd = bus1.write_data;
      o[1].wt = bus1.write_tag_array; o[1].fv = bus1.fwd_valid;
      o[1].fd = bus1.fwd_data; o[1].dn = bus1.fill_done;
      o[1].dv = bus1.mem_data_valid; o[1].dd = bus1.mem_data;
      o[1].rdy = rdy; o[1].miss = miss; o[1].ma = maddr;
      for (int i = 0; i < 2; i++) step(i, o[i]);
      chk("timeout", 32'(tmo), 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // md: 0 ready always, 1 ready 1,0,0 pattern, 2 random ready
  task automatic run_fill(input logic [15:0] a, input int l, input int md,
                          input bit hold, input int cut);
    int t;
    int ph;
    lat   = l;
    miss  = 1'b1;
    maddr = a;
    rdy   = 1'b1;
    @(posedge clk); #1;
    if (hold) maddr = a ^ 16'h0F08;
    else miss = 1'b0;
    t  = 0;
    ph = 0;
    while ((m_busy[0] || m_busy[1]) && t < 500) begin
      if (hold && (m_rsp[0] == W - 1 || m_rsp[1] == W - 1)) miss = 1'b0;
      if (cut >= 0 && m_rsp[0] == cut) begin
        rst_n = 1'b0;
        miss  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      case (md)
        0: rdy = 1'b1;
        1: rdy = (ph % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      ph++;
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) tmo = 1'b1;
    miss = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 32768; k++) mem[k] = 16'($urandom);
    rst_n = 1'b0;
    miss  = 1'b0;
    maddr = '0;
    rdy   = 1'b0;
    spur  = 1'b0;
    tmo   = 1'b0;
    lat   = 1;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    run_fill(16'h1236, 1, 0, 0, -1);
    run_fill(16'h1236, 4, 0, 0, -1);
    run_fill(16'h4A5E, 2, 1, 0, -1);
    run_fill(16'h7000, 3, 0, 0, -1);
    spur = 1'b1;
    idle(6);
    run_fill(16'h80F2, 3, 2, 1, -1);
    idle(4);
    spur = 1'b0;
    run_fill(16'h1236, 1, 0, 0, 5);
    idle(2);
    run_fill(16'h1236, 1, 0, 0, -1);
    for (int n = 0; n < 24; n++) begin
      spur = 1'($urandom);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 4));
      run_fill(16'($urandom), $urandom_range(1, 5),
               $urandom_range(0, 2), 1'($urandom), -1);
    end
    spur = 1'b0;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
